// File: rtl/riscv_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states and lane helpers.
package riscv_pkg;

    localparam logic [1:0] Byte_Access     = 2'b00;
    localparam logic [1:0] Halfword_Access = 2'b01;
    localparam logic [1:0] Word_Access     = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

    // True when the access cannot be served: unaligned halfword/word, or the reserved size code.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            Byte_Access:     return 1'b0;
            Halfword_Access: return off[0];
            Word_Access:     return off != 2'b00;
            default:         return 1'b1;
        endcase
    endfunction

    // Byte lanes touched by an aligned access of the given size at the given word offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            Byte_Access:     return 4'b0001 << off;
            Halfword_Access: return 4'b0011 << {off[1], 1'b0};
            default:         return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/riscv_dmem_sram.sv
// Word-wide data storage: byte-lane write enables, synchronous write, combinational read.
module riscv_dmem_sram #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                       clk,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [3:0]                 be,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata
);

    logic [31:0] mem [DEPTH];

    // Update only the enabled byte lanes of the addressed word; contents have no reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder: accepts one load/store at a time and answers after a fixed latency.
module riscv_dmem_resp
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_byte_i,
    input  logic        data_zero_extnd_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int unsigned LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

    dmem_state_e   state;
    logic [CW-1:0] cnt;

    logic [AW+1:0] req_addr;
    logic          req_wr;
    logic [1:0]    req_byte;
    logic          req_zx;
    logic [31:0]   req_wdata;

    logic [1:0]    off;
    logic          misaligned;
    logic [3:0]    sram_be;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;
    logic [31:0]   shifted;
    logic [31:0]   load_val;
    logic          unused_addr_hi;

    // Address bits above the memory span wrap around and are deliberately dropped.
    assign unused_addr_hi = ^data_addr_i[31:AW+2];

    assign data_gnt_o = (state == IDLE);
    assign off        = req_addr[1:0];
    assign misaligned = is_misaligned(req_byte, off);

    // Request capture and latency sequencing; reset drops any request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_addr  <= '0;
            req_wr    <= 1'b0;
            req_byte  <= '0;
            req_zx    <= 1'b0;
            req_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req_i) begin
                        req_addr  <= data_addr_i[AW+1:0];
                        req_wr    <= data_wr_i;
                        req_byte  <= data_byte_i;
                        req_zx    <= data_zero_extnd_i;
                        req_wdata <= data_wdata_i;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                            cnt   <= CW'(LOAD);
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Replicate store data across lanes so the lane enables alone select the destination.
    always_comb begin
        case (req_byte)
            Byte_Access:     sram_wdata = {4{req_wdata[7:0]}};
            Halfword_Access: sram_wdata = {2{req_wdata[15:0]}};
            default:         sram_wdata = req_wdata;
        endcase
    end

    // Right-align the selected lanes and extend to 32 bits.
    always_comb begin
        shifted = sram_rdata >> {off, 3'b000};
        case (req_byte)
            Byte_Access:     load_val = req_zx ? {24'h0, shifted[7:0]}
                                               : {{24{shifted[7]}}, shifted[7:0]};
            Halfword_Access: load_val = req_zx ? {16'h0, shifted[15:0]}
                                               : {{16{shifted[15]}}, shifted[15:0]};
            default:         load_val = sram_rdata;
        endcase
    end

    // Response strobe, error, read data and store enables exist only in RESP outside reset.
    always_comb begin
        data_rvalid_o = 1'b0;
        data_err_o    = 1'b0;
        data_rdata_o  = '0;
        sram_be       = '0;
        if (state == RESP && !reset) begin
            data_rvalid_o = 1'b1;
            if (misaligned) begin
                data_err_o = 1'b1;
            end else if (req_wr) begin
                sram_be = lane_mask(req_byte, off);
            end else begin
                data_rdata_o = load_val;
            end
        end
    end

    riscv_dmem_sram #(
        .DEPTH(DEPTH)
    ) u_sram (
        .clk   (clk),
        .addr  (req_addr[AW+1:2]),
        .be    (sram_be),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Scoreboard bench for riscv_dmem_resp: driver pushes expected responses, monitor pops and checks.
module tb_riscv_dmem_resp;
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] addr = '0;
    logic        wr = 1'b0;
    logic [1:0]  sz = '0;
    logic        zx = 1'b0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    always #5 clk = ~clk;

    riscv_dmem_resp #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .data_req_i        (req),
        .data_gnt_o        (gnt),
        .data_addr_i       (addr),
        .data_wr_i         (wr),
        .data_byte_i       (sz),
        .data_zero_extnd_i (zx),
        .data_wdata_i      (wdata),
        .data_rvalid_o     (rvalid),
        .data_rdata_o      (rdata),
        .data_err_o        (err)
    );

    typedef struct {
        int          acc;
        logic        err;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          pulses = 0;
    int          last_acc = 0;
    logic [7:0]  mb [4*DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Byte-array memory model: sizes 1/2/4, alignment by modulo, wrap by byte-address modulo.
    function automatic void model(input logic [31:0] a, input logic w, input logic [1:0] s,
                                  input logic z, input logic [31:0] wd,
                                  output logic e, output logic [31:0] rd);
        int n, off, base;
        n   = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : (s == 2'b10) ? 4 : 0;
        off = int'(a % 4);
        rd  = '0;
        e   = 1'b0;
        if (n == 0) e = 1'b1;
        else if (off % n != 0) e = 1'b1;
        if (e) return;
        base = int'(a % (4 * DEPTH));
        for (int i = 0; i < n; i++) begin
            if (w) mb[base + i] = wd[8*i +: 8];
            else   rd |= 32'(mb[base + i]) << (8 * i);
        end
        if (!w && n < 4 && !z && rd[8*n-1]) rd |= 32'hFFFF_FFFF << (8 * n);
        if (w) rd = '0;
    endfunction

    task automatic junk();
        addr  = $urandom;
        wr    = 1'($urandom);
        sz    = 2'($urandom);
        zx    = 1'($urandom);
        wdata = $urandom;
    endtask

    // Hold req high until granted, scrambling inputs while not granted; push expectation on grant.
    task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] s, input logic z,
                         input logic [31:0] wd, input bit expect_resp, input bit use_lit,
                         input logic [31:0] lit_rd, input logic lit_err, input string name);
        exp_t        e;
        logic        m_err;
        logic [31:0] m_rd;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            req = 1'b1;
            if (gnt) begin
                addr = a; wr = w; sz = s; zx = z; wdata = wd;
                if (expect_resp) begin
                    model(a, w, s, z, wd, m_err, m_rd);
                    e.acc   = cyc;
                    e.name  = name;
                    e.err   = use_lit ? lit_err : m_err;
                    e.rdata = use_lit ? lit_rd : m_rd;
                    sb.push_back(e);
                end
                last_acc = cyc;
                @(posedge clk);
                return;
            end
            junk();
        end
        check({name, "_gnt_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic lit(input logic [31:0] a, input logic w, input logic [1:0] s, input logic z,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input string name);
        issue(a, w, s, z, wd, 1'b1, 1'b1, exp_rd, exp_err, name);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = 1'b0;
            junk();
        end
    endtask

    task automatic drain();
        @(negedge clk);
        req = 1'b0;
        for (int t = 0; t < 64; t++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every response pops one expectation; idle cycles must show zero outputs.
    always @(negedge clk) begin
        if (rvalid) begin
            pulses++;
            if (sb.size() == 0) begin
                check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc), 32'(LAT));
                check({mon_e.name, "_err"}, 32'(err), 32'(mon_e.err));
                check({mon_e.name, "_rdata"}, rdata, mon_e.rdata);
            end
        end else begin
            check("idle_err", 32'(err), 32'd0);
            check("idle_rdata", rdata, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          a0, a1, a2, p0;
        logic [31:0] ra;

        repeat (3) @(negedge clk);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_gnt", 32'(gnt), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_gnt", 32'(gnt), 32'd1);

        for (int i = 0; i < 64; i++) issue(32'(4 * i), 1'b1, Word_Access, 1'b0, $urandom, 1'b1, 1'b0, '0, 1'b0, "prewrite");
        lit(32'h200, 1'b1, Word_Access, 1'b0, 32'h1122_3344, 32'h0, 1'b0, "sw200");

        lit(32'h100, 1'b1, Word_Access, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw100");
        lit(32'h100, 1'b0, Word_Access, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw100");
        lit(32'h102, 1'b1, Byte_Access, 1'b0, 32'h1234_56AA, 32'h0, 1'b0, "sb102");
        lit(32'h102, 1'b0, Byte_Access, 1'b0, 32'h0, 32'hFFFF_FFAA, 1'b0, "lb102");
        lit(32'h102, 1'b0, Byte_Access, 1'b1, 32'h0, 32'h0000_00AA, 1'b0, "lbu102");
        lit(32'h102, 1'b0, Halfword_Access, 1'b0, 32'h0, 32'hFFFF_DEAA, 1'b0, "lh102");
        lit(32'h100, 1'b0, Word_Access, 1'b0, 32'h0, 32'hDEAA_BEEF, 1'b0, "lw100b");
        lit(32'h101, 1'b1, Word_Access, 1'b0, 32'h1234_5678, 32'h0, 1'b1, "sw101_mis");
        lit(32'h100, 1'b0, Word_Access, 1'b0, 32'h0, 32'hDEAA_BEEF, 1'b0, "lw100c");
        lit(32'h103, 1'b0, Halfword_Access, 1'b0, 32'h0, 32'h0, 1'b1, "lh103_mis");
        lit(32'h100, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, "size11_mis");
        drain();

        // Continuous request: three back-to-back accepts spaced LAT+1 cycles.
        p0 = pulses;
        lit(32'h100, 1'b0, Halfword_Access, 1'b1, 32'h0, 32'h0000_BEEF, 1'b0, "burst0");
        a0 = last_acc;
        lit(32'h102, 1'b0, Halfword_Access, 1'b1, 32'h0, 32'h0000_DEAA, 1'b0, "burst1");
        a1 = last_acc;
        lit(32'h103, 1'b0, Byte_Access, 1'b0, 32'h0, 32'hFFFF_FFDE, 1'b0, "burst2");
        a2 = last_acc;
        drain();
        check("burst_space01", 32'(a1 - a0), 32'(LAT + 1));
        check("burst_space12", 32'(a2 - a1), 32'(LAT + 1));
        check("burst_pulses", 32'(pulses - p0), 32'd3);

        // Reset while the store waits: no response and no write.
        issue(32'h200, 1'b1, Word_Access, 1'b0, 32'h5566_7788, 1'b0, 1'b0, '0, 1'b0, "sw200_killed");
        @(negedge clk);
        req = 1'b0;
        check("rst_in_wait_gnt", 32'(gnt), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_gnt", 32'(gnt), 32'd1);
        idle(4);
        lit(32'h200, 1'b0, Word_Access, 1'b0, 32'h0, 32'h1122_3344, 1'b0, "lw200_after_rst");

        // Upper address bits wrap onto the same words.
        lit(32'h1000, 1'b1, Word_Access, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0, "sw1000");
        lit(32'h0, 1'b0, Word_Access, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, "lw0_wrap");

        for (int i = 0; i < 250; i++) begin
            ra = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            issue(ra, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom,
                  1'b1, 1'b0, '0, 1'b0, "rand");
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_dmem_resp.md
RISCV_DMEM_RESP -- requirements
Module: riscv_dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning data memory size in 32-bit words; it SHALL be a power of two.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response; it SHALL be at least 1.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_req_i  input  1  core requests a load/store.
REQ-006 data_gnt_o  output  1  responder accepts the request this cycle.
REQ-007 data_addr_i  input  32  byte address.
REQ-008 data_wr_i  input  1  1 = store, 0 = load.
REQ-009 data_byte_i  input  2  access size: Byte_Access, Halfword_Access or Word_Access.
REQ-010 data_zero_extnd_i  input  1  load result zero-extended when 1, sign-extended when 0.
REQ-011 data_wdata_i  input  32  store data, right-aligned.
REQ-012 data_rvalid_o  output  1  one-cycle response strobe.
REQ-013 data_rdata_o  output  32  load result, right-aligned and extended.
REQ-014 data_err_o  output  1  response carries an error; valid only with data_rvalid_o.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 SHALL assert data_gnt_o exactly when state is IDLE, combinationally and independent of data_req_i.
REQ-017 Acceptance: data_req_i and data_gnt_o high at a rising edge.
- SHALL register addr, wr, byte, zero_extnd and wdata at acceptance.
- Inputs outside acceptance cycles SHALL be ignored.
REQ-018 Transitions from IDLE on acceptance SHALL be:
- to WAIT with counter loaded to LATENCY-2 when LATENCY>1;
- to RESP when LATENCY==1.
REQ-019 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL move to RESP in the cycle the counter is 0.
REQ-020 RESP SHALL last exactly one cycle, then return to IDLE; data_rvalid_o SHALL be high only in RESP.
- Accept at edge N -> data_rvalid_o high in cycle N+LATENCY.
- Next grant in cycle N+LATENCY+1.
REQ-021 Word index SHALL be addr[$clog2(DEPTH)+1:2]; upper address bits SHALL be ignored (wrap-around).
REQ-022 Misalignment SHALL be: halfword with addr[0]=1, word with addr[1:0]!=0, or data_byte_i==2'b11.
- Response: data_err_o=1, data_rdata_o=0, no memory write.
REQ-023 Aligned store SHALL write in the RESP cycle only:
- byte: wdata[7:0] to lane addr[1:0];
- halfword: wdata[15:0] to lanes {addr[1],0}+1:+0;
- word: all four lanes.
- Other lanes unchanged; data_rdata_o=0; data_err_o=0.
REQ-024 Aligned load SHALL select lanes the same way, shift them to bit 0 and sign-extend from bit 7/15, or zero-extend when zero_extnd=1; word loads are unaffected by zero_extnd.
REQ-025 Outside RESP, data_rvalid_o, data_err_o and data_rdata_o SHALL be 0.
REQ-026 A store followed by a load to the same word SHALL return the stored data (no stale read).

Reset
REQ-027 Reset SHALL force state IDLE, counter 0, captured request 0, data_rvalid_o=0, data_err_o=0, data_rdata_o=0; data_gnt_o=1 in the cycle after reset.
REQ-028 Reset mid-operation (WAIT or RESP) SHALL discard the pending request: no response and no memory write.
REQ-029 Memory contents SHALL NOT be affected by reset.

Structure
REQ-030 Byte_Access/Halfword_Access/Word_Access encodings and the FSM state enum SHALL live in riscv_pkg; the module SHALL import riscv_pkg.
REQ-031 Storage SHALL be a sub-module riscv_dmem_sram: DEPTH x 32 array, 4-bit byte write enable, synchronous write, combinational read.

Verification
REQ-032 Word store addr 0x100, wdata 0xDEADBEEF, then word load 0x100 -> rvalid exactly LATENCY cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-033 Following REQ-032:
- byte store 0xAA at 0x102;
- LB 0x102 -> 0xFFFFFFAA;
- LBU 0x102 -> 0x000000AA;
- LH 0x102 -> 0xFFFFDEAA;
- LW 0x100 -> 0xDEAABEEF.
REQ-034 Misaligned word store at 0x101 with 0x12345678 -> err 1, rdata 0; subsequent LW 0x100 unchanged.
REQ-035 data_req_i held high continuously for 3 requests with LATENCY=3 -> grants spaced 4 cycles apart, exactly 3 rvalid pulses.
REQ-036 Reset asserted in WAIT of a store to 0x200 -> no rvalid; LW 0x200 after reset returns the prior contents.
REQ-037 With DEPTH=1024, store at 0x1000 then load at 0x0 -> same data (wrap-around).
